ctrl_seq: RTL and testbench



---
 rtl/ctrl_seq_pkg.sv | 40 ++++
 rtl/ctrl_seq_if.sv | 32 +++
 rtl/ctrl_decode_comb.sv | 56 +++++
 rtl/ctrl_seq.sv | 95 +++++++++
 tb/tb_ctrl_seq.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/ctrl_seq_pkg.sv
// Shared definitions for the sequenced control unit: opcode/funct encodings,
// the registered strobe bundle and the sequencer state.
package ctrl_seq_pkg;

  typedef enum logic [2:0] {
    opADD   = 3'd0,
    opSUB   = 3'd1,
    opLW    = 3'd2,
    opSW    = 3'd3,
    opCEQ   = 3'd4,
    opCLT   = 3'd5,
    opSEI   = 3'd6,
    opOTHER = 3'd7
  } opcode_t;

  localparam logic [2:0] fnB0   = 3'd0;
  localparam logic [2:0] fnB1   = 3'd1;
  localparam logic [2:0] fnHALT = 3'd7;

  typedef struct packed {
    logic branch_en;
    logic flag_write;
    logic overflow_write;
    logic mem_read;
    logic mem_write;
    logic reg_wr_en;
    logic reg_wr_imm_en;
  } ctrl_t;

  typedef enum logic [1:0] {
    EXEC     = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  function automatic logic is_mem_op(input ctrl_t c);
    return c.mem_read | c.mem_write;
  endfunction

endpackage

// File: rtl/ctrl_seq_if.sv
// Fetch-side handshake plus the control strobes driven toward datapath and memory.
interface ctrl_seq_if #(
  parameter int IW = 9
);
  // instr_valid/instr_ready: an instruction transfers on a clock edge where
  // both are high; Instruction and FLAG_IN must be stable while instr_valid is high.
  logic          instr_valid;
  logic [IW-1:0] Instruction;
  logic          FLAG_IN;
  logic          instr_ready;
  logic          branch_en;
  logic          flag_write;
  logic          overflow_write;
  logic          MEM_READ;
  logic          MEM_WRITE;
  logic          reg_wr_en;
  logic          reg_wr_imm_en;
  logic          pc_stall;
  logic          done;

  modport master (
    output instr_valid, Instruction, FLAG_IN,
    input  instr_ready, branch_en, flag_write, overflow_write, MEM_READ,
           MEM_WRITE, reg_wr_en, reg_wr_imm_en, pc_stall, done
  );

  modport slave (
    input  instr_valid, Instruction, FLAG_IN,
    output instr_ready, branch_en, flag_write, overflow_write, MEM_READ,
           MEM_WRITE, reg_wr_en, reg_wr_imm_en, pc_stall, done
  );
endinterface

// File: rtl/ctrl_decode_comb.sv
// Pure combinational decode of one instruction (plus the current compare flag)
// into the strobe bundle and a halt indication.
module ctrl_decode_comb
  import ctrl_seq_pkg::*;
#(
  parameter int IW  = 9,
  parameter int OPW = 3,
  parameter int FNW = 3
) (
  input  logic [IW-1:0] instr,
  input  logic          flag_in,
  output ctrl_t         ctrl,
  output logic          halt
);

  logic [OPW-1:0] op;
  logic [FNW-1:0] fn;
  logic           unused_bits;

  assign op          = instr[IW-1 -: OPW];
  assign fn          = instr[FNW-1:0];
  assign unused_bits = ^instr[IW-OPW-1:FNW];

  always_comb begin
    ctrl = '0;
    halt = 1'b0;
    case (op)
      opADD, opSUB: begin
        ctrl.overflow_write = 1'b1;
        ctrl.reg_wr_en      = 1'b1;
      end
      opCEQ, opCLT: ctrl.flag_write = 1'b1;
      opSEI: begin
        ctrl.reg_wr_en     = 1'b1;
        ctrl.reg_wr_imm_en = 1'b1;
      end
      opSW: ctrl.mem_write = 1'b1;
      // LW requests a write-back; the sequencer delays it to the last memory cycle.
      opLW: begin
        ctrl.mem_read  = 1'b1;
        ctrl.reg_wr_en = 1'b1;
      end
      opOTHER: begin
        if (fn == fnB0)        ctrl.branch_en = !flag_in;
        else if (fn == fnB1)   ctrl.branch_en = flag_in;
        else if (fn == fnHALT) halt = 1'b1;
        else begin
          ctrl.overflow_write = 1'b1;
          ctrl.reg_wr_en      = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_seq.sv
// Sequenced control unit: accepts one instruction per handshake, registers the
// decoded strobes, stretches LW/SW over MEM_LAT cycles and parks in HALT.
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int IW      = 9,
  parameter int OPW     = 3,
  parameter int FNW     = 3,
  parameter int MEM_LAT = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  ctrl_seq_if.slave   bus,
  output state_t      dbg_state
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t        state;
  ctrl_t         ctrl_q;
  ctrl_t         dec;
  logic          dec_halt;
  logic          done_q;
  logic          accept;
  logic [CW-1:0] cnt;

  ctrl_decode_comb #(
    .IW  (IW),
    .OPW (OPW),
    .FNW (FNW)
  ) u_decode (
    .instr   (bus.Instruction),
    .flag_in (bus.FLAG_IN),
    .ctrl    (dec),
    .halt    (dec_halt)
  );

  assign accept = bus.instr_valid && (state == EXEC);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= EXEC;
      ctrl_q <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        EXEC: begin
          ctrl_q <= '0;
          if (accept) begin
            ctrl_q <= dec;
            if (dec_halt) begin
              state  <= HALT;
              done_q <= 1'b1;
            end else if ((MEM_LAT > 1) && is_mem_op(dec)) begin
              state            <= MEM_WAIT;
              cnt              <= CW'(MEM_LAT - 1);
              ctrl_q.reg_wr_en <= 1'b0;
            end
          end
        end
        // Memory strobe stays up; LW write-back joins it on the final cycle.
        MEM_WAIT: begin
          if (cnt == CW'(1)) begin
            state            <= EXEC;
            ctrl_q.reg_wr_en <= ctrl_q.mem_read;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HALT: begin
          ctrl_q <= '0;
          done_q <= 1'b1;
        end
        default: begin
          state  <= EXEC;
          ctrl_q <= '0;
        end
      endcase
    end
  end

  assign bus.instr_ready    = (state == EXEC);
  assign bus.pc_stall       = (state == MEM_WAIT) || (state == HALT);
  assign bus.done           = done_q;
  assign bus.branch_en      = ctrl_q.branch_en;
  assign bus.flag_write     = ctrl_q.flag_write;
  assign bus.overflow_write = ctrl_q.overflow_write;
  assign bus.MEM_READ       = ctrl_q.mem_read;
  assign bus.MEM_WRITE      = ctrl_q.mem_write;
  assign bus.reg_wr_en      = ctrl_q.reg_wr_en;
  assign bus.reg_wr_imm_en  = ctrl_q.reg_wr_imm_en;
  assign dbg_state          = state;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: three instances (MEM_LAT = 1, 3, 2) share clock,
// reset and stimulus; a vector table plus hand sequences check each one.
module tb_ctrl_seq;
  import ctrl_seq_pkg::*;

  logic   Clk;
  logic   Reset;
  state_t st1, st3, st2;

  ctrl_seq_if #(.IW(9)) f1 ();
  ctrl_seq_if #(.IW(9)) f3 ();
  ctrl_seq_if #(.IW(9)) f2 ();

  ctrl_seq #(.IW(9), .OPW(3), .FNW(3), .MEM_LAT(1)) u_l1 (
    .Clk(Clk), .Reset(Reset), .bus(f1), .dbg_state(st1));
  ctrl_seq #(.IW(9), .OPW(3), .FNW(3), .MEM_LAT(3)) u_l3 (
    .Clk(Clk), .Reset(Reset), .bus(f3), .dbg_state(st3));
  ctrl_seq #(.IW(9), .OPW(3), .FNW(3), .MEM_LAT(2)) u_l2 (
    .Clk(Clk), .Reset(Reset), .bus(f2), .dbg_state(st2));

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // observation word: {branch, flag_wr, ovf_wr, mem_rd, mem_wr, reg_wr, imm, ready, stall, done}
  typedef struct {
    logic       valid;
    logic [8:0] instr;
    logic       flag;
    logic [9:0] exp;
  } vec_t;

  int         checks;
  int         errors;
  vec_t       vecs[14];
  logic [9:0] exp_q[$];

  function automatic logic [8:0] mk(input logic [2:0] op, input logic [2:0] fn);
    return {op, 3'b000, fn};
  endfunction

  function automatic logic [9:0] obs1();
    return {f1.branch_en, f1.flag_write, f1.overflow_write, f1.MEM_READ, f1.MEM_WRITE,
            f1.reg_wr_en, f1.reg_wr_imm_en, f1.instr_ready, f1.pc_stall, f1.done};
  endfunction

  function automatic logic [9:0] obs3();
    return {f3.branch_en, f3.flag_write, f3.overflow_write, f3.MEM_READ, f3.MEM_WRITE,
            f3.reg_wr_en, f3.reg_wr_imm_en, f3.instr_ready, f3.pc_stall, f3.done};
  endfunction

  function automatic logic [9:0] obs2();
    return {f2.branch_en, f2.flag_write, f2.overflow_write, f2.MEM_READ, f2.MEM_WRITE,
            f2.reg_wr_en, f2.reg_wr_imm_en, f2.instr_ready, f2.pc_stall, f2.done};
  endfunction

  // driver tasks
  task automatic drive(input logic valid, input logic [8:0] instr, input logic flag);
    f1.instr_valid = valid; f1.Instruction = instr; f1.FLAG_IN = flag;
    f3.instr_valid = valid; f3.Instruction = instr; f3.FLAG_IN = flag;
    f2.instr_valid = valid; f2.Instruction = instr; f2.FLAG_IN = flag;
  endtask

  task automatic do_reset();
    drive(1'b0, 9'd0, 1'b0);
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // scoreboard
  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input state_t act, input state_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got state %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset  = 1'b1;
    drive(1'b0, 9'd0, 1'b0);

    vecs[0]  = '{1'b1, mk(opADD,   3'd0),   1'b0, 10'b0010010_100};
    vecs[1]  = '{1'b1, mk(opSUB,   3'd2),   1'b1, 10'b0010010_100};
    vecs[2]  = '{1'b1, mk(opCEQ,   3'd0),   1'b0, 10'b0100000_100};
    vecs[3]  = '{1'b1, mk(opSEI,   3'd5),   1'b0, 10'b0000011_100};
    vecs[4]  = '{1'b1, mk(opCLT,   3'd0),   1'b1, 10'b0100000_100};
    vecs[5]  = '{1'b0, mk(opADD,   3'd0),   1'b0, 10'b0000000_100};
    vecs[6]  = '{1'b1, mk(opOTHER, fnB0),   1'b0, 10'b1000000_100};
    vecs[7]  = '{1'b1, mk(opOTHER, fnB0),   1'b1, 10'b0000000_100};
    vecs[8]  = '{1'b1, mk(opOTHER, fnB1),   1'b0, 10'b0000000_100};
    vecs[9]  = '{1'b1, mk(opOTHER, fnB1),   1'b1, 10'b1000000_100};
    vecs[10] = '{1'b1, mk(opOTHER, 3'd3),   1'b0, 10'b0010010_100};
    vecs[11] = '{1'b1, mk(opSW,    3'd0),   1'b0, 10'b0000100_100};
    vecs[12] = '{1'b1, mk(opLW,    3'd0),   1'b0, 10'b0001010_100};
    vecs[13] = '{1'b0, mk(opLW,    3'd0),   1'b0, 10'b0000000_100};

    // reset state
    do_reset();
    check("reset_l1", obs1(), 10'b0000000_100);
    check("reset_l3", obs3(), 10'b0000000_100);
    check_state("reset_state_l1", st1, EXEC);

    // vector table on the MEM_LAT=1 instance
    foreach (vecs[i]) exp_q.push_back(vecs[i].exp);
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].valid, vecs[i].instr, vecs[i].flag);
      step();
      check($sformatf("vec%0d", i), obs1(), exp_q.pop_front());
    end

    // LW with MEM_LAT=3; valid pulses during the wait must be ignored
    do_reset();
    drive(1'b1, mk(opLW, 3'd0), 1'b0);
    step();
    check("lw3_c1", obs3(), 10'b0001000_010);
    check_state("lw3_state", st3, MEM_WAIT);
    drive(1'b1, mk(opADD, 3'd0), 1'b0);
    step();
    check("lw3_c2", obs3(), 10'b0001000_010);
    step();
    check("lw3_c3", obs3(), 10'b0001010_100);
    step();
    check("lw3_next_add", obs3(), 10'b0010010_100);

    // HALT holds despite instr_valid, released only by reset
    do_reset();
    drive(1'b1, mk(opOTHER, fnHALT), 1'b0);
    step();
    check("halt_enter", obs1(), 10'b0000000_011);
    drive(1'b1, mk(opADD, 3'd0), 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("halt_hold%0d", i), obs1(), 10'b0000000_011);
    end
    check_state("halt_state", st1, HALT);
    Reset = 1'b1;
    #1;
    check("halt_reset_async", obs1(), 10'b0000000_100);
    check_state("halt_reset_state", st1, EXEC);

    // reset mid-SW with MEM_LAT=2, then a clean SW
    do_reset();
    drive(1'b1, mk(opSW, 3'd0), 1'b0);
    step();
    check("sw2_c1", obs2(), 10'b0000100_010);
    drive(1'b0, 9'd0, 1'b0);
    #1 Reset = 1'b1;
    #1;
    check("sw2_abort", obs2(), 10'b0000000_100);
    check_state("sw2_abort_state", st2, EXEC);
    Reset = 1'b0;
    @(negedge Clk);
    drive(1'b1, mk(opSW, 3'd0), 1'b0);
    step();
    check("sw2_again_c1", obs2(), 10'b0000100_010);
    drive(1'b0, 9'd0, 1'b0);
    step();
    check("sw2_again_c2", obs2(), 10'b0000100_100);
    step();
    check("sw2_again_idle", obs2(), 10'b0000000_100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
